// File: rtl/coin_pkg.sv
// Shared types and constants for the coin sprite renderer.
// Optional blink-in-POP behaviour is enabled with the COIN_FLASH_EN macro.
package coin_pkg;
  typedef enum logic [1:0] {IDLE, SPIN, POP, DONE} coin_state_t;

  localparam int          SPRITE_W_DEF = 20;
  localparam int          SPRITE_H_DEF = 20;
  localparam int          ADDR_W       = 9;
  localparam int          COORD_W      = 10;
  localparam int          COLOR_W      = 12;
  localparam logic [11:0] TRANSPARENT  = 12'h808;

  function automatic logic [1:0] next_frame(input logic [1:0] f);
    return f + 2'd1;
  endfunction
endpackage

// File: rtl/coin_anim_ctrl.sv
// Coin lifecycle FSM with spin-frame timing, pop rise and position registers.
// With COIN_FLASH_EN defined, o_blank requests blinking during POP.
module coin_anim_ctrl
  import coin_pkg::*;
#(
  parameter int TICKS_PER_STEP = 6,
  parameter int POP_STEPS      = 16,
  parameter int POP_DY         = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_tick,
  input  logic               i_spawn,
  input  logic [COORD_W-1:0] i_spawn_x,
  input  logic [COORD_W-1:0] i_spawn_y,
  input  logic               i_collect,
  output coin_state_t        o_state,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [1:0]         o_frame,
  output logic               o_blank
);
  localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int POP_W  = (POP_STEPS > 4) ? $clog2(POP_STEPS) : 2;

  coin_state_t        r_state;
  logic [COORD_W-1:0] r_x, r_y;
  logic [1:0]         r_frame;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [POP_W-1:0]   r_pop_cnt;

  logic w_moving;
  assign w_moving = (r_state == SPIN) || (r_state == POP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_frame    <= '0;
      r_tick_cnt <= '0;
      r_pop_cnt  <= '0;
    end else if (i_spawn) begin
      // a fresh spawn overrides everything, including a same-cycle collect
      r_state    <= SPIN;
      r_x        <= i_spawn_x;
      r_y        <= i_spawn_y;
      r_frame    <= '0;
      r_tick_cnt <= '0;
      r_pop_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE:    r_state <= IDLE;
        SPIN:    if (i_collect) r_state <= POP;
        POP:     if (i_frame_tick && r_pop_cnt == POP_W'(POP_STEPS - 1)) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (i_frame_tick && w_moving) begin
        if (r_tick_cnt == TICK_W'(TICKS_PER_STEP - 1)) begin
          r_tick_cnt <= '0;
          r_frame    <= next_frame(r_frame);
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end
      if (i_frame_tick && r_state == POP) begin
        r_y       <= (r_y < COORD_W'(POP_DY)) ? '0 : r_y - COORD_W'(POP_DY);
        r_pop_cnt <= r_pop_cnt + 1'b1;
      end
    end
  end

  assign o_state = r_state;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_frame = r_frame;

`ifdef COIN_FLASH_EN
  assign o_blank = (r_state == POP) && r_pop_cnt[1];
`else
  assign o_blank = 1'b0;
`endif
endmodule

// File: rtl/coin_sprite_renderer.sv
// Coin sprite reader: beam-to-ROM address pipeline plus keyed pixel output.
// Define COIN_FLASH_EN to blink the coin while it pops.
module coin_sprite_renderer
  import coin_pkg::*;
#(
  parameter int SPRITE_W       = SPRITE_W_DEF,
  parameter int SPRITE_H       = SPRITE_H_DEF,
  parameter int TICKS_PER_STEP = 6,
  parameter int POP_STEPS      = 16,
  parameter int POP_DY         = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic               collect,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COLOR_W-1:0] rom_color,
  output logic [ADDR_W-1:0]  read_address,
  output logic [1:0]         frame_sel,
  output logic               pixel_on,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               coin_active,
  output logic               collected
);
  coin_state_t        w_state;
  logic [COORD_W-1:0] w_x, w_y;
  logic [1:0]         w_frame;
  logic               w_blank;

  coin_anim_ctrl #(
    .TICKS_PER_STEP(TICKS_PER_STEP),
    .POP_STEPS     (POP_STEPS),
    .POP_DY        (POP_DY)
  ) u_ctrl (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_frame_tick(frame_tick),
    .i_spawn     (spawn),
    .i_spawn_x   (spawn_x),
    .i_spawn_y   (spawn_y),
    .i_collect   (collect),
    .o_state     (w_state),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_frame     (w_frame),
    .o_blank     (w_blank)
  );

  assign coin_active = (w_state == SPIN) || (w_state == POP);
  assign collected   = (w_state == DONE);

  // one extra bit keeps the beam-left/above-sprite case from wrapping into the box
  logic [COORD_W:0]  w_dx, w_dy;
  logic              w_in_box;
  logic [ADDR_W-1:0] w_addr;

  assign w_dx     = {1'b0, DrawX} - {1'b0, w_x};
  assign w_dy     = {1'b0, DrawY} - {1'b0, w_y};
  assign w_in_box = coin_active
                 && !w_dx[COORD_W] && (w_dx[COORD_W-1:0] < COORD_W'(SPRITE_W))
                 && !w_dy[COORD_W] && (w_dy[COORD_W-1:0] < COORD_W'(SPRITE_H));
  assign w_addr   = ADDR_W'(w_dy[COORD_W-1:0]) * ADDR_W'(SPRITE_W) + ADDR_W'(w_dx[COORD_W-1:0]);

  logic              r_in_box;
  logic [ADDR_W-1:0] r_read_address;
  logic [1:0]        r_frame_sel;
  logic              r_pixel_on;
  logic [COLOR_W-1:0] r_pixel_color;
  logic              w_opaque;

  assign w_opaque = r_in_box && (rom_color != TRANSPARENT) && !w_blank;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_in_box       <= 1'b0;
      r_read_address <= '0;
      r_frame_sel    <= '0;
      r_pixel_on     <= 1'b0;
      r_pixel_color  <= '0;
    end else begin
      r_in_box       <= w_in_box;
      r_read_address <= w_in_box ? w_addr : '0;
      r_frame_sel    <= w_frame;
      r_pixel_on     <= w_opaque;
      r_pixel_color  <= w_opaque ? rom_color : '0;
    end
  end

  assign read_address = r_read_address;
  assign frame_sel    = r_frame_sel;
  assign pixel_on     = r_pixel_on;
  assign pixel_color  = r_pixel_color;
endmodule

// File: tb/tb_coin_sprite_renderer.sv
// Self-checking bench: coin lifecycle model driven by total tick / pop counts.
module tb_coin_sprite_renderer;
  logic       Clk = 1'b0, Reset_n = 1'b0;
  logic       frame_tick = 1'b0, spawn = 1'b0, collect = 1'b0;
  logic [9:0] spawn_x = '0, spawn_y = '0, DrawX = '0, DrawY = '0;
  logic [11:0] rom_color;
  logic [8:0] read_address;
  logic [1:0] frame_sel;
  logic       pixel_on, coin_active, collected;
  logic [11:0] pixel_color;

  always #5 Clk = ~Clk;

  coin_sprite_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .collect(collect),
    .DrawX(DrawX), .DrawY(DrawY), .rom_color(rom_color),
    .read_address(read_address), .frame_sel(frame_sel), .pixel_on(pixel_on),
    .pixel_color(pixel_color), .coin_active(coin_active), .collected(collected)
  );

  logic        rom_force = 1'b0;
  logic [11:0] rom_fval  = '0;

  function automatic logic [11:0] rom_fn(input int f, input int a);
    int h;
    h = (a * 37 + f * 101 + 5) % 4096;
    if (h % 9 == 0) return 12'h808;
    return 12'(h);
  endfunction

  function automatic int rom_of(input int f, input int a);
    return rom_force ? int'(rom_fval) : int'(rom_fn(f, a));
  endfunction

  always_comb rom_color = rom_force ? rom_fval : rom_fn(int'(frame_sel), int'(read_address));

  // model: states 0 idle, 1 spin, 2 pop, 3 done; frame and y derived from totals
  int m_st, m_x, m_sy, m_pops, m_ticks;
  int e_addr, e_fsel, e_inb, e_on, e_col;

  function automatic int my_y(input int sy, input int pops);
    return (sy - 2 * pops < 0) ? 0 : sy - 2 * pops;
  endfunction

  function automatic int my_frame(input int t);
    return (t / 6) % 4;
  endfunction

  function automatic int my_blank(input int st, input int pops);
`ifdef COIN_FLASH_EN
    return (st == 2 && ((pops / 2) % 2) == 1) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int in_box(input int st, input int dx, input int dy, input int x, input int y);
    return ((st == 1 || st == 2) && dx >= x && dx - x < 20 && dy >= y && dy - y < 20) ? 1 : 0;
  endfunction

  function automatic int exp_on(input int inb, input int f, input int a, input int st, input int pops);
    return (inb == 1 && rom_of(f, a) != 'h808 && my_blank(st, pops) == 0) ? 1 : 0;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_st <= 0; m_x <= 0; m_sy <= 0; m_pops <= 0; m_ticks <= 0;
      e_addr <= 0; e_fsel <= 0; e_inb <= 0; e_on <= 0; e_col <= 0;
    end else begin
      e_on   <= exp_on(e_inb, e_fsel, e_addr, m_st, m_pops);
      e_col  <= exp_on(e_inb, e_fsel, e_addr, m_st, m_pops) ? rom_of(e_fsel, e_addr) : 0;
      e_inb  <= in_box(m_st, int'(DrawX), int'(DrawY), m_x, my_y(m_sy, m_pops));
      e_addr <= in_box(m_st, int'(DrawX), int'(DrawY), m_x, my_y(m_sy, m_pops)) ?
                (int'(DrawY) - my_y(m_sy, m_pops)) * 20 + int'(DrawX) - m_x : 0;
      e_fsel <= my_frame(m_ticks);
      if (spawn) begin
        m_st <= 1; m_x <= int'(spawn_x); m_sy <= int'(spawn_y); m_pops <= 0; m_ticks <= 0;
      end else begin
        if (frame_tick && (m_st == 1 || m_st == 2)) m_ticks <= m_ticks + 1;
        if (m_st == 1 && collect) m_st <= 2;
        if (m_st == 2 && frame_tick) begin
          m_pops <= m_pops + 1;
          if (m_pops + 1 == 16) m_st <= 3;
        end
        if (m_st == 3) m_st <= 0;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // advance one clock, compare every output against the model, clear pulses
  task automatic cyc();
    @(negedge Clk);
    chk("read_address", int'(read_address), e_addr);
    chk("frame_sel", int'(frame_sel), e_fsel);
    chk("pixel_on", int'(pixel_on), e_on);
    chk("pixel_color", int'(pixel_color), e_col);
    chk("coin_active", int'(coin_active), (m_st == 1 || m_st == 2) ? 1 : 0);
    chk("collected", int'(collected), (m_st == 3) ? 1 : 0);
    spawn = 1'b0; collect = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    int ncol;
    int sx, sy;
    int yexp[6];
    yexp = '{40, 80, 120, 160, 200, 200};

    cyc(); cyc();
    chk("rst_addr", int'(read_address), 0);
    chk("rst_active", int'(coin_active), 0);
    chk("rst_color", int'(pixel_color), 0);
    Reset_n = 1'b1;
    cyc();

    // spawn at (100,200), beam at (105,203)
    spawn = 1'b1; spawn_x = 10'd100; spawn_y = 10'd200;
    cyc();
    DrawX = 10'd105; DrawY = 10'd203; rom_force = 1'b1; rom_fval = 12'hF30;
    cyc();
    chk("lit_addr65", int'(read_address), 65);
    cyc();
    chk("lit_on", int'(pixel_on), 1);
    chk("lit_colF30", int'(pixel_color), 'hF30);
    rom_fval = 12'h808;
    cyc();
    chk("lit_transp_on", int'(pixel_on), 0);
    chk("lit_transp_col", int'(pixel_color), 0);
    rom_fval = 12'hF30; DrawX = 10'd120;
    cyc();
    chk("lit_out_addr", int'(read_address), 0);
    cyc();
    chk("lit_out_on", int'(pixel_on), 0);

    // spin frame sequence
    chk("lit_frame0", int'(frame_sel), 0);
    for (int k = 1; k <= 24; k++) begin
      frame_tick = 1'b1;
      cyc(); cyc();
      if (k == 5) chk("lit_frame_k5", int'(frame_sel), 0);
      if (k % 6 == 0) chk("lit_frame_step", int'(frame_sel), (k / 6) % 4);
    end

    // asynchronous reset in the middle of SPIN
    DrawX = 10'd105;
    for (int k = 0; k < 6; k++) begin frame_tick = 1'b1; cyc(); end
    cyc();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_active", int'(coin_active), 0);
    chk("arst_addr", int'(read_address), 0);
    chk("arst_fsel", int'(frame_sel), 0);
    chk("arst_on", int'(pixel_on), 0);
    chk("arst_coll", int'(collected), 0);
    cyc();
    Reset_n = 1'b1;
    cyc();

    // collect at y=10, watch the rise through the ROM address
    spawn = 1'b1; spawn_x = 10'd50; spawn_y = 10'd10; DrawX = 10'd50; DrawY = 10'd10;
    cyc();
    collect = 1'b1;
    cyc();
    ncol = 0;
    for (int p = 1; p <= 20; p++) begin
      frame_tick = 1'b1;
      cyc();
      if (collected) ncol++;
      cyc();
      if (collected) ncol++;
      if (p <= 6) chk("lit_pop_addr", int'(read_address), yexp[p-1]);
`ifdef COIN_FLASH_EN
      if (p <= 15) chk("lit_flash", int'(pixel_on), ((p / 2) % 2 == 1) ? 0 : 1);
`else
      if (p <= 15) chk("lit_noflash", int'(pixel_on), 1);
`endif
    end
    chk("lit_collected_once", ncol, 1);
    chk("lit_done_inactive", int'(coin_active), 0);

    // spawn beats collect in the same cycle
    spawn = 1'b1; spawn_x = 10'd300; spawn_y = 10'd100;
    cyc();
    for (int k = 0; k < 6; k++) begin frame_tick = 1'b1; cyc(); end
    spawn = 1'b1; collect = 1'b1; spawn_x = 10'd400; spawn_y = 10'd50;
    DrawX = 10'd403; DrawY = 10'd51;
    cyc();
    chk("lit_sim_active", int'(coin_active), 1);
    cyc();
    chk("lit_sim_addr", int'(read_address), 23);
    chk("lit_sim_frame", int'(frame_sel), 0);
    ncol = 0;
    for (int k = 0; k < 20; k++) begin
      frame_tick = 1'b1;
      cyc();
      if (collected) ncol++;
    end
    chk("lit_sim_nopop", ncol, 0);
    chk("lit_sim_still_active", int'(coin_active), 1);

    // randomized traffic
    rom_force = 1'b0;
    sx = 400; sy = 50;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        spawn = 1'b1;
        sx = (i % 5 == 0) ? int'($urandom_range(1005, 1023)) : int'($urandom_range(0, 639));
        sy = (i % 7 == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 479));
        spawn_x = 10'(sx); spawn_y = 10'(sy);
      end
      collect    = ($urandom_range(0, 24) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        DrawX = 10'(sx + int'($urandom_range(0, 23)) - 2);
        DrawY = 10'(my_y(sy, m_pops) + int'($urandom_range(0, 23)) - 2);
      end else begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end
      if (i % 750 == 749) begin
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
